// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter between instruction fetch and load/store
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  cnt;         // index of the byte currently on the bus
    logic [1:0]  last_cnt;    // index of the final byte of this transaction
    logic        last_grant;  // 0 = icache served last, 1 = LSU served last
    logic        wr_reg;
    logic [23:0] wbuf;        // store bytes 1..3, latched at grant

    logic        ls_blocked;
    logic        ic_want;
    logic        ls_want;
    logic        grant_ic;
    logic        grant_ls;
    logic        can_grant;
    logic [1:0]  ls_last;
    logic [7:0]  next_wbyte;

    // The strobe drops immediately whenever the system is paused
    assign mem_wr = wr_reg & rdy_in;

    // Arbitration: stores to the UART window wait for buffer space; ties go to the side not served last
    always_comb begin
        ls_blocked = ls_wr && (ls_addr[17:16] == 2'b11) && io_buffer_full;
        ic_want    = ic_req;
        ls_want    = ls_req && !ls_blocked;
        grant_ls   = ls_want && (!ic_want || !last_grant);
        grant_ic   = ic_want && (!ls_want || last_grant);
        // A done pulse still showing means the requester has not yet dropped its request
        can_grant  = !clear_in && !ic_done && !ls_done;
    end

    // Transfer length and next store byte selection
    always_comb begin
        case (ls_size)
            2'd0:    ls_last = 2'd0;
            2'd1:    ls_last = 2'd1;
            default: ls_last = 2'd3;
        endcase
        case (cnt)
            2'd0:    next_wbyte = wbuf[7:0];
            2'd1:    next_wbyte = wbuf[15:8];
            default: next_wbyte = wbuf[23:16];
        endcase
    end

    // Main FSM: grant, step bytes across the RAM port, pulse done, return to IDLE
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last_cnt   <= 2'd0;
            last_grant <= 1'b0;
            wr_reg     <= 1'b0;
            wbuf       <= 24'd0;
            mem_a      <= 32'd0;
            mem_dout   <= 8'd0;
            ic_done    <= 1'b0;
            ic_data    <= 32'd0;
            ls_done    <= 1'b0;
            ls_rdata   <= 32'd0;
        end else if (rdy_in) begin
            ic_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_grant && grant_ls) begin
                        last_grant <= 1'b1;
                        mem_a      <= ls_addr;
                        cnt        <= 2'd0;
                        last_cnt   <= ls_last;
                        if (ls_wr) begin
                            state    <= LS_WRITE;
                            wr_reg   <= 1'b1;
                            mem_dout <= ls_wdata[7:0];
                            wbuf     <= ls_wdata[31:8];
                        end else begin
                            state    <= LS_READ;
                            ls_rdata <= 32'd0;
                        end
                    end else if (can_grant && grant_ic) begin
                        last_grant <= 1'b0;
                        mem_a      <= ic_addr;
                        cnt        <= 2'd0;
                        last_cnt   <= 2'd3;
                        state      <= IC_READ;
                    end
                end
                IC_READ, LS_READ: begin
                    if (clear_in) begin
                        state <= IDLE;
                        mem_a <= 32'd0;
                    end else begin
                        if (state == IC_READ) begin
                            ic_data[{cnt, 3'b000} +: 8] <= mem_din;
                        end else begin
                            ls_rdata[{cnt, 3'b000} +: 8] <= mem_din;
                        end
                        if (cnt == last_cnt) begin
                            state <= IDLE;
                            mem_a <= 32'd0;
                            if (state == IC_READ) begin
                                ic_done <= 1'b1;
                            end else begin
                                ls_done <= 1'b1;
                            end
                        end else begin
                            mem_a <= mem_a + 32'd1;
                            cnt   <= cnt + 2'd1;
                        end
                    end
                end
                LS_WRITE: begin
                    if (cnt == last_cnt) begin
                        state   <= IDLE;
                        wr_reg  <= 1'b0;
                        mem_a   <= 32'd0;
                        ls_done <= 1'b1;
                    end else begin
                        mem_a    <= mem_a + 32'd1;
                        mem_dout <= next_wbyte;
                        cnt      <= cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
